bus_mem: RTL and testbench

BUS_MEM -- requirements
Module: bus_mem

---
 rtl/bus_mem.sv | 139 +++++++++++++
 tb/tb_bus_mem.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem.sv
// Word-addressed memory slave on a shared tri-state bus with a fixed number of wait states.
// Latency: Ready pulses WAIT_CYCLES+1 edges after the request is sampled (illegal requests: 1 edge).
// Backpressure: none; a strobe held past Ready parks the FSM in RELEASE until both strobes drop.
module bus_mem #(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire  [DATA_W-1:0]     BUS,
    input  logic                  Memread,
    input  logic                  Memwrite,
    input  logic [31:0]           Addr,
    input  logic [DATA_W/8-1:0]   ByteEn,
    output logic                  Ready,
    output logic                  Err
);

    localparam int NB    = DATA_W / 8;
    localparam int LSB   = $clog2(NB);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, DONE, RELEASE} state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       start;

    logic                  req_rd, req_wr, req_err;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic [NB-1:0]         req_be;
    logic [DATA_W-1:0]     req_dat;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata;

    logic [31:0]           off;
    logic                  live_err;
    logic [DEPTH_LOG2-1:0] live_idx;

    assign off      = Addr - BASE_ADDR;
    assign live_idx = off[LSB +: DEPTH_LOG2];
    assign live_err = (Addr < BASE_ADDR)
                   || ((Addr & 32'(NB - 1)) != 32'd0)
                   || ((off >> (LSB + DEPTH_LOG2)) != 32'd0)
                   || (Memread && Memwrite);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (Memread || Memwrite) begin
                    start = 1'b1;
                    if ((Memread && Memwrite) || (WAIT_CYCLES == 0)) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    state_nxt = DONE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                state_nxt = (Memread || Memwrite) ? RELEASE : IDLE;
            end
            RELEASE: begin
                if (!Memread && !Memwrite) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            req_rd  <= 1'b0;
            req_wr  <= 1'b0;
            req_err <= 1'b0;
            req_idx <= '0;
            req_be  <= '0;
            req_dat <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (start) begin
                req_rd  <= Memread && !Memwrite;
                req_wr  <= Memwrite && !Memread;
                req_err <= live_err;
                req_idx <= live_idx;
                req_be  <= ByteEn;
                req_dat <= BUS;
            end
        end
    end

    // With zero wait states DONE is entered on the request edge itself, so the
    // array must see the live request rather than the not-yet-loaded registers.
    logic                  in_idle, enter_done;
    logic                  acc_wr, acc_err;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [NB-1:0]         acc_be;
    logic [DATA_W-1:0]     acc_dat;

    assign in_idle    = (state == IDLE);
    assign enter_done = !rst && (state != DONE) && (state_nxt == DONE);
    assign acc_wr     = in_idle ? (Memwrite && !Memread) : req_wr;
    assign acc_err    = in_idle ? live_err : req_err;
    assign acc_idx    = in_idle ? live_idx : req_idx;
    assign acc_be     = in_idle ? ByteEn   : req_be;
    assign acc_dat    = in_idle ? BUS      : req_dat;

    always_ff @(posedge clk) begin
        if (enter_done) begin
            if (acc_wr && !acc_err) begin
                for (int b = 0; b < NB; b++) begin
                    if (acc_be[b]) mem[acc_idx][b*8 +: 8] <= acc_dat[b*8 +: 8];
                end
            end
            rdata <= acc_err ? '0 : mem[acc_idx];
        end
    end

    assign Ready = (state == DONE);
    assign Err   = (state == DONE) && req_err;
    assign BUS   = ((state == DONE) && req_rd) ? rdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_mem.sv
// Directed bench for bus_mem: default instance (32-bit, 2 wait states) and a 16-bit zero-wait instance.
module tb_bus_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        rd0, wr0, drv0, rdy0, err0;
    logic [31:0] addr0, wd0;
    logic [3:0]  be0;
    tri1  [31:0] bus0;
    assign bus0 = drv0 ? wd0 : 32'hz;

    logic        rd1, wr1, drv1, rdy1, err1;
    logic [31:0] addr1;
    logic [15:0] wd1;
    logic [1:0]  be1;
    tri1  [15:0] bus1;
    assign bus1 = drv1 ? wd1 : 16'hz;

    bus_mem u0 (
        .clk(clk), .rst(rst), .BUS(bus0), .Memread(rd0), .Memwrite(wr0),
        .Addr(addr0), .ByteEn(be0), .Ready(rdy0), .Err(err0)
    );

    bus_mem #(.DATA_W(16), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .BUS(bus1), .Memread(rd1), .Memwrite(wr1),
        .Addr(addr1), .ByteEn(be1), .Ready(rdy1), .Err(err1)
    );

    int nchk  = 0;
    int npass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Waits (bounded) for Ready on u0; pre holds the bus seen on the last non-Ready cycle.
    task automatic wait_rdy0(output int edges, output logic err, output logic [31:0] dat,
                             output logic [31:0] pre);
        logic seen;
        seen = 1'b0; edges = 0; err = 1'b0; dat = '0; pre = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            edges++;
            if (rdy0) begin
                seen = 1'b1; err = err0; dat = bus0;
            end else begin
                pre = bus0;
            end
        end
    endtask

    task automatic acc0(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        output int edges, output logic err, output logic [31:0] dat,
                        output logic [31:0] pre);
        @(negedge clk);
        rd0 = rd; wr0 = wr; addr0 = a; be0 = be; wd0 = wd; drv0 = wr;
        wait_rdy0(edges, err, dat, pre);
        @(negedge clk);
        rd0 = 1'b0; wr0 = 1'b0; drv0 = 1'b0;
        @(posedge clk); #1;
        check({tag, "/rdy_after"}, rdy0, 1'b0);
        check({tag, "/bus_after"}, bus0, 32'hFFFF_FFFF);
    endtask

    task automatic acc1(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [1:0] be, input logic [15:0] wd,
                        output int edges, output logic err, output logic [15:0] dat);
        logic seen;
        seen = 1'b0; edges = 0; err = 1'b0; dat = '0;
        @(negedge clk);
        rd1 = rd; wr1 = wr; addr1 = a; be1 = be; wd1 = wd; drv1 = wr;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            edges++;
            if (rdy1) begin
                seen = 1'b1; err = err1; dat = bus1;
            end
        end
        @(negedge clk);
        rd1 = 1'b0; wr1 = 1'b0; drv1 = 1'b0;
        @(posedge clk);
    endtask

    int          e;
    logic        er;
    logic [31:0] d, p;
    logic [15:0] d16;
    int          pulses;
    logic        ill_err;

    initial begin
        rst = 1'b1;
        rd0 = 0; wr0 = 0; drv0 = 0; addr0 = '0; be0 = '0; wd0 = '0;
        rd1 = 0; wr1 = 0; drv1 = 0; addr1 = '0; be1 = '0; wd1 = '0;
        #12;
        check("reset/ready", rdy0, 1'b0);
        check("reset/err", err0, 1'b0);
        check("reset/bus", bus0, 32'hFFFF_FFFF);
        check("reset/ready16", rdy1, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        acc0("wr10", 0, 1, 32'h10, 4'hF, 32'hDEAD_BEEF, e, er, d, p);
        check("wr10/edges", e, 3);
        check("wr10/err", er, 1'b0);

        acc0("rd10", 1, 0, 32'h10, 4'h0, 32'h0, e, er, d, p);
        check("rd10/edges", e, 3);
        check("rd10/err", er, 1'b0);
        check("rd10/data", d, 32'hDEAD_BEEF);
        check("rd10/bus_wait", p, 32'hFFFF_FFFF);

        acc0("bytewr", 0, 1, 32'h10, 4'b0001, 32'h0000_00AA, e, er, d, p);
        acc0("rdbyte", 1, 0, 32'h10, 4'h0, 32'h0, e, er, d, p);
        check("rdbyte/data", d, 32'hDEAD_BEAA);

        acc0("wr0", 0, 1, 32'h0, 4'hF, 32'h0BAD_F00D, e, er, d, p);
        acc0("rdmis", 1, 0, 32'h1002, 4'hF, 32'h0, e, er, d, p);
        check("rdmis/err", er, 1'b1);
        check("rdmis/data", d, 32'h0);
        acc0("rdoor", 1, 0, 32'h1000, 4'hF, 32'h0, e, er, d, p);
        check("rdoor/err", er, 1'b1);
        check("rdoor/data", d, 32'h0);
        acc0("wroor", 0, 1, 32'h1000, 4'hF, 32'h1234_5678, e, er, d, p);
        check("wroor/err", er, 1'b1);
        acc0("rd0", 1, 0, 32'h0, 4'h0, 32'h0, e, er, d, p);
        check("rd0/unchanged", d, 32'h0BAD_F00D);
        acc0("rd10b", 1, 0, 32'h10, 4'h0, 32'h0, e, er, d, p);
        check("rd10b/unchanged", d, 32'hDEAD_BEAA);

        // Both strobes high and held: one Ready with Err, then parked until release.
        @(negedge clk);
        rd0 = 1'b1; wr0 = 1'b1; addr0 = 32'h10; be0 = 4'hF;
        pulses = 0; ill_err = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            if (rdy0) begin
                pulses++; ill_err = err0;
            end
        end
        check("illegal/pulses", pulses, 1);
        check("illegal/err", ill_err, 1'b1);
        check("illegal/bus_held", bus0, 32'hFFFF_FFFF);
        @(negedge clk);
        rd0 = 1'b0; wr0 = 1'b0;
        @(posedge clk);
        acc0("rdill", 1, 0, 32'h10, 4'h0, 32'h0, e, er, d, p);
        check("rdill/unchanged", d, 32'hDEAD_BEAA);

        // Reset while an erroneous read is in DONE releases the bus at once.
        @(negedge clk);
        rd0 = 1'b1; addr0 = 32'h1000;
        wait_rdy0(e, er, d, p);
        check("rstdone/bus_before", d, 32'h0);
        #2 rst = 1'b1;
        #1;
        check("rstdone/ready", rdy0, 1'b0);
        check("rstdone/err", err0, 1'b0);
        check("rstdone/bus", bus0, 32'hFFFF_FFFF);
        @(negedge clk);
        rd0 = 1'b0;
        rst = 1'b0;

        acc0("wr20", 0, 1, 32'h20, 4'hF, 32'hCAFE_F00D, e, er, d, p);

        // Reset during the WAIT of a write, with a read already pending at release.
        @(negedge clk);
        wr0 = 1'b1; addr0 = 32'h20; be0 = 4'hF; wd0 = 32'h1234_5678; drv0 = 1'b1;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rstwait/ready", rdy0, 1'b0);
        @(negedge clk);
        wr0 = 1'b0; drv0 = 1'b0; rd0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_rdy0(e, er, d, p);
        check("rstwait/edges", e, 3);
        check("rstwait/data", d, 32'hCAFE_F00D);
        @(negedge clk);
        rd0 = 1'b0;
        @(posedge clk);

        acc1(0, 1, 32'h4, 2'b11, 16'hBEEF, e, er, d16);
        check("w16/edges", e, 1);
        check("w16/err", er, 1'b0);
        acc1(1, 0, 32'h4, 2'b00, 16'h0, e, er, d16);
        check("r16/edges", e, 1);
        check("r16/data", d16, 16'hBEEF);
        acc1(0, 1, 32'h4, 2'b10, 16'h1200, e, er, d16);
        acc1(1, 0, 32'h4, 2'b00, 16'h0, e, er, d16);
        check("r16byte/data", d16, 16'h12EF);
        acc1(1, 0, 32'h3, 2'b11, 16'h0, e, er, d16);
        check("r16mis/err", er, 1'b1);
        check("r16mis/data", d16, 16'h0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
